writeback: RTL and testbench
============================

// Module: writeback
// PURPOSE
//  Final pipeline stage of the RV32I_Zicsr core, directly downstream of the memory stage.
//  Takes the memory stage's registered result and drives the register-file write port.
//  For loads, that result is the raw aligned load word.
//  Loads: extracts the addressed byte/half and sign- or zero-extends it.
//  Flags illegal or misaligned loads. Emits a one-cycle retire pulse per completed instruction.
// PARAMETERS
//  CNT_W    64   width of retired-instruction counter (instret), used only with WB_INSTRET_EN
//  (XLEN, XADDR and OPLEN come from header.vh and are not parameters.)
// PORTS
//  i_clk          in   1      core clock; all state on posedge
//  i_rst          in   1      reset, asynchronous, active-high
//  i_pc           in   XLEN   PC of the instruction in WB
//  i_opcode       in   OPLEN  opcode from the memory stage
//  i_funct3       in   3      funct3 from the memory stage (load width/sign)
//  i_rd_addr      in   XADDR  destination register
//  i_rd_write     in   1      rd write request
//  i_rd_data      in   XLEN   ALU result, or raw 32-bit load word when opcode==L_OP
//  i_addr_lo      in   2      low bits of the load effective address
//  i_stall        in   1      pipeline stall
//  i_flush        in   1      pipeline flush
//  o_rf_we        out  1      register-file write enable
//  o_rf_addr      out  XADDR  register-file write address
//  o_rf_data      out  XLEN   register-file write data
//  o_pc           out  XLEN   PC of the retiring instruction
//  o_retire       out  1      one-cycle pulse: instruction retired
//  o_load_fault   out  1      one-cycle pulse: illegal or misaligned load killed
//  o_instret      out  CNT_W  retired-instruction count (present only with WB_INSTRET_EN)
// BEHAVIOUR
//  - Every output is registered; latency is 1 cycle from input to output.
//  - Reset (async, i_rst=1): every output and the counter go to 0 immediately. No write leaks
//    on the edge of reset deassertion. Reset mid-instruction discards that instruction.
//  - Priority per clock edge: i_flush > i_stall > normal.
//  - Flush: o_rf_we=0, o_retire=0, o_load_fault=0; o_rf_addr, o_rf_data and o_pc are cleared to 0.
//  - Stall: o_rf_we, o_retire and o_load_fault are forced to 0, so no duplicate writes occur.
//    o_rf_addr, o_rf_data and o_pc hold. The counter holds.
//  - Normal cycle:
//    - o_rf_we = i_rd_write & (i_rd_addr != 0) & ~fault.
//    - o_retire = (i_opcode != 0) & ~fault. Opcode 0 is the reset/bubble value and never retires.
//  - Load extraction (i_opcode == L_OP), keyed on i_funct3:
//    - 000 LB: byte[i_addr_lo], sign-extended.
//    - 001 LH: half[i_addr_lo[1]], sign-extended.
//    - 010 LW: full word.
//    - 100 LBU: byte[i_addr_lo], zero-extended.
//    - 101 LHU: half[i_addr_lo[1]], zero-extended.
//    - byte[n] = i_rd_data[8n+7:8n].
//  - Load fault: funct3 in {011,110,111}; LH/LHU with i_addr_lo[0]=1; LW with i_addr_lo!=0.
//    Outcome: o_load_fault=1, o_rf_we=0, o_retire=0; o_rf_data is 0.
//  - Non-load opcodes: o_rf_data = i_rd_data unchanged.
//    S_OP and B_OP retire with o_rf_we=0 because their i_rd_write is 0.
//  - Widths: all extraction is XLEN=32 bits. No arithmetic outside the counter.
// CONFIGURATION
//  - Macro WB_INSTRET_EN defined: o_instret port and the CNT_W counter exist.
//    - Counter increments by 1 in each cycle that o_retire is registered 1 (same edge).
//    - Wraps from 2^CNT_W-1 to 0 with no flag.
//  - Macro undefined: no o_instret port and no counter flops; all other behaviour is identical.
// STRUCTURE
//  - header.vh (shared): L_OP, S_OP, B_OP, I_OP, XLEN, XADDR, OPLEN, plus new load-funct3
//    constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU, shared with the memory stage.
//  - Sub-module load_align (combinational): inputs word, addr_lo, funct3.
//    Outputs: data[XLEN-1:0] and fault.
//  - Top level holds the output register, stall/flush priority and the optional counter.
// TESTING
//  1. L_OP, F3_LB, word=0x80FF1234, addr_lo=3, rd=x5, we=1 -> next cycle:
//     o_rf_we=1, o_rf_addr=5, o_rf_data=0xFFFFFF80, o_retire=1.
//  2. L_OP, F3_LHU, word=0x80FF1234, addr_lo=2 -> o_rf_data=0x000080FF.
//     Same word with F3_LH, addr_lo=1 -> o_load_fault=1, o_rf_we=0, o_retire=0.
//  3. I_OP, rd=x0, i_rd_write=1, data=0xDEADBEEF -> o_rf_we=0, o_retire=1.
//     Same with rd=x7 -> o_rf_we=1, o_rf_data=0xDEADBEEF.
//  4. Valid R_OP write held with i_stall=1 for 3 cycles -> o_rf_we=0 and o_retire=0 all
//     3 cycles, o_rf_data held. i_stall and i_flush together -> all outputs cleared.
//  5. Assert i_rst between clock edges during a load -> all outputs are 0 before the next edge.
//     Release -> first instruction after release writes normally.
//  6. With WB_INSTRET_EN, counter forced to 64'hFFFF_FFFF_FFFF_FFFF, one I_OP retires
//     -> o_instret=0. Without the macro, the same stimulus compiles and passes tests 1-5.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared core constants: opcodes, widths and load funct3 encodings.
package writeback_pkg;

    localparam int XLEN  = 32;
    localparam int XADDR = 5;
    localparam int OPLEN = 7;

    localparam logic [OPLEN-1:0] L_OP = 7'b0000011;
    localparam logic [OPLEN-1:0] S_OP = 7'b0100011;
    localparam logic [OPLEN-1:0] B_OP = 7'b1100011;
    localparam logic [OPLEN-1:0] I_OP = 7'b0010011;
    localparam logic [OPLEN-1:0] R_OP = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_if.sv
// Memory-stage to writeback bundle plus register-file write port.
interface writeback_if;
    import writeback_pkg::*;

    logic [XLEN-1:0]  i_pc;
    logic [OPLEN-1:0] i_opcode;
    logic [2:0]       i_funct3;
    logic [XADDR-1:0] i_rd_addr;
    logic             i_rd_write;
    logic [XLEN-1:0]  i_rd_data;
    logic [1:0]       i_addr_lo;
    logic             i_stall;
    logic             i_flush;

    logic             o_rf_we;
    logic [XADDR-1:0] o_rf_addr;
    logic [XLEN-1:0]  o_rf_data;
    logic [XLEN-1:0]  o_pc;
    logic             o_retire;
    logic             o_load_fault;

    modport master (
        output i_pc, i_opcode, i_funct3, i_rd_addr, i_rd_write,
        output i_rd_data, i_addr_lo, i_stall, i_flush,
        input  o_rf_we, o_rf_addr, o_rf_data, o_pc, o_retire,
        input  o_load_fault
    );

    modport slave (
        input  i_pc, i_opcode, i_funct3, i_rd_addr, i_rd_write,
        input  i_rd_data, i_addr_lo, i_stall, i_flush,
        output o_rf_we, o_rf_addr, o_rf_data, o_pc, o_retire,
        output o_load_fault
    );

endinterface

// File: rtl/writeback_load_align.sv
// Combinational load extractor: picks byte/half from the aligned word,
// extends it, and flags illegal widths or misaligned addresses.
module load_align
    import writeback_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{addr_lo, 3'b000} +: 8];
    assign h = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data  = '0;
        fault = 1'b0;
        unique case (1'b1)
            funct3 == F3_LB:  data = {{24{b[7]}}, b};
            funct3 == F3_LBU: data = {24'h0, b};
            funct3 == F3_LH: begin
                fault = addr_lo[0];
                data  = fault ? '0 : {{16{h[15]}}, h};
            end
            funct3 == F3_LHU: begin
                fault = addr_lo[0];
                data  = fault ? '0 : {16'h0, h};
            end
            funct3 == F3_LW: begin
                fault = |addr_lo;
                data  = fault ? '0 : word;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: registers the result onto the register-file port.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module writeback
    import writeback_pkg::*;
`ifdef WB_INSTRET_EN
#(
    parameter int CNT_W = 64
)
`endif
(
    input  logic             i_clk,
    input  logic             i_rst,
    writeback_if.slave       bus
`ifdef WB_INSTRET_EN
    ,
    output logic [CNT_W-1:0] o_instret
`endif
);

    logic [XLEN-1:0]  al_data;
    logic             al_fault;
    logic             is_load;
    logic             flt;
    logic             retire_d;

    logic             rf_we_q;
    logic [XADDR-1:0] rf_addr_q;
    logic [XLEN-1:0]  rf_data_q;
    logic [XLEN-1:0]  pc_q;
    logic             retire_q;
    logic             fault_q;

    load_align u_align (
        .word    (bus.i_rd_data),
        .addr_lo (bus.i_addr_lo),
        .funct3  (bus.i_funct3),
        .data    (al_data),
        .fault   (al_fault)
    );

    assign is_load  = bus.i_opcode == L_OP;
    assign flt      = is_load & al_fault;
    assign retire_d = (|bus.i_opcode) & ~flt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            pc_q      <= '0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else if (bus.i_flush) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            pc_q      <= '0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else if (bus.i_stall) begin
            // strobes drop so a held instruction never writes twice
            rf_we_q   <= 1'b0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            rf_we_q   <= bus.i_rd_write & (|bus.i_rd_addr) & ~flt;
            rf_addr_q <= bus.i_rd_addr;
            rf_data_q <= is_load ? al_data : bus.i_rd_data;
            pc_q      <= bus.i_pc;
            retire_q  <= retire_d;
            fault_q   <= flt;
        end
    end

    assign bus.o_rf_we      = rf_we_q;
    assign bus.o_rf_addr    = rf_addr_q;
    assign bus.o_rf_data    = rf_data_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_retire     = retire_q;
    assign bus.o_load_fault = fault_q;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            instret_q <= '0;
        else if (!bus.i_flush && !bus.i_stall && retire_d)
            instret_q <= instret_q + 1'b1;
    end

    assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage.
module tb_writeback;
    import writeback_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    writeback_if bus ();

`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    writeback dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
`ifdef WB_INSTRET_EN
        ,
        .o_instret (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] d, input logic [1:0] lo,
                         input logic [31:0] pc);
        bus.i_opcode   = op;
        bus.i_funct3   = f3;
        bus.i_rd_addr  = rd;
        bus.i_rd_write = we;
        bus.i_rd_data  = d;
        bus.i_addr_lo  = lo;
        bus.i_pc       = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(7'd0, 3'd0, 5'd0, 1'b0, 32'h0, 2'd0, 32'h0);
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({bus.o_rf_we, bus.o_retire, bus.o_load_fault} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000",
                     {bus.o_rf_we, bus.o_retire, bus.o_load_fault});
        end
        checks++;
        if ({bus.o_rf_addr, bus.o_rf_data, bus.o_pc} !== 69'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {bus.o_rf_addr, bus.o_rf_data, bus.o_pc});
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_load_lb();
        drive(L_OP, F3_LB, 5'd5, 1'b1, 32'h80FF1234, 2'd3, 32'h100);
        step();
        checks++;
        if (bus.o_rf_we !== 1'b1 || bus.o_rf_addr !== 5'd5) begin
            failures++;
            $display("FAIL lb_we got=%b/%0d exp=1/5", bus.o_rf_we, bus.o_rf_addr);
        end
        checks++;
        if (bus.o_rf_data !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL lb_data got=%h exp=ffffff80", bus.o_rf_data);
        end
        checks++;
        if (bus.o_retire !== 1'b1 || bus.o_load_fault !== 1'b0 || bus.o_pc !== 32'h100) begin
            failures++;
            $display("FAIL lb_retire got=%b/%b/%h exp=1/0/100",
                     bus.o_retire, bus.o_load_fault, bus.o_pc);
        end
        drive(L_OP, F3_LB, 5'd5, 1'b1, 32'h80FF1234, 2'd0, 32'h104);
        step();
        checks++;
        if (bus.o_rf_data !== 32'h00000034) begin
            failures++;
            $display("FAIL lb0_data got=%h exp=00000034", bus.o_rf_data);
        end
        drive(L_OP, F3_LBU, 5'd5, 1'b1, 32'h80FF1234, 2'd3, 32'h108);
        step();
        checks++;
        if (bus.o_rf_data !== 32'h00000080) begin
            failures++;
            $display("FAIL lbu_data got=%h exp=00000080", bus.o_rf_data);
        end
    endtask

    task automatic test_load_half_word();
        drive(L_OP, F3_LHU, 5'd6, 1'b1, 32'h80FF1234, 2'd2, 32'h10C);
        step();
        checks++;
        if (bus.o_rf_data !== 32'h000080FF || bus.o_rf_we !== 1'b1) begin
            failures++;
            $display("FAIL lhu_data got=%h/%b exp=000080ff/1", bus.o_rf_data, bus.o_rf_we);
        end
        drive(L_OP, F3_LH, 5'd6, 1'b1, 32'h80FF1234, 2'd2, 32'h110);
        step();
        checks++;
        if (bus.o_rf_data !== 32'hFFFF80FF) begin
            failures++;
            $display("FAIL lh_data got=%h exp=ffff80ff", bus.o_rf_data);
        end
        drive(L_OP, F3_LH, 5'd6, 1'b1, 32'h80FF1234, 2'd1, 32'h114);
        step();
        checks++;
        if ({bus.o_load_fault, bus.o_rf_we, bus.o_retire} !== 3'b100 ||
            bus.o_rf_data !== 32'h0) begin
            failures++;
            $display("FAIL lh_misalign got=%b%b%b/%h exp=100/0",
                     bus.o_load_fault, bus.o_rf_we, bus.o_retire, bus.o_rf_data);
        end
        drive(L_OP, F3_LW, 5'd6, 1'b1, 32'h80FF1234, 2'd0, 32'h118);
        step();
        checks++;
        if (bus.o_rf_data !== 32'h80FF1234 || bus.o_load_fault !== 1'b0) begin
            failures++;
            $display("FAIL lw_data got=%h/%b exp=80ff1234/0", bus.o_rf_data, bus.o_load_fault);
        end
        drive(L_OP, F3_LW, 5'd6, 1'b1, 32'h80FF1234, 2'd2, 32'h11C);
        step();
        checks++;
        if ({bus.o_load_fault, bus.o_rf_we, bus.o_retire} !== 3'b100) begin
            failures++;
            $display("FAIL lw_misalign got=%b%b%b exp=100",
                     bus.o_load_fault, bus.o_rf_we, bus.o_retire);
        end
        drive(L_OP, 3'b011, 5'd6, 1'b1, 32'h80FF1234, 2'd0, 32'h120);
        step();
        checks++;
        if ({bus.o_load_fault, bus.o_rf_we, bus.o_retire} !== 3'b100) begin
            failures++;
            $display("FAIL f3_illegal got=%b%b%b exp=100",
                     bus.o_load_fault, bus.o_rf_we, bus.o_retire);
        end
    endtask

    task automatic test_alu();
        drive(I_OP, 3'd0, 5'd0, 1'b1, 32'hDEADBEEF, 2'd0, 32'h200);
        step();
        checks++;
        if (bus.o_rf_we !== 1'b0 || bus.o_retire !== 1'b1) begin
            failures++;
            $display("FAIL x0_write got=%b/%b exp=0/1", bus.o_rf_we, bus.o_retire);
        end
        drive(I_OP, 3'd0, 5'd7, 1'b1, 32'hDEADBEEF, 2'd3, 32'h204);
        step();
        checks++;
        if (bus.o_rf_we !== 1'b1 || bus.o_rf_data !== 32'hDEADBEEF ||
            bus.o_rf_addr !== 5'd7) begin
            failures++;
            $display("FAIL x7_write got=%b/%h/%0d exp=1/deadbeef/7",
                     bus.o_rf_we, bus.o_rf_data, bus.o_rf_addr);
        end
        drive(S_OP, 3'd2, 5'd3, 1'b0, 32'h12345678, 2'd0, 32'h208);
        step();
        checks++;
        if (bus.o_rf_we !== 1'b0 || bus.o_retire !== 1'b1) begin
            failures++;
            $display("FAIL store_retire got=%b/%b exp=0/1", bus.o_rf_we, bus.o_retire);
        end
        drive(7'd0, 3'd0, 5'd4, 1'b0, 32'h0, 2'd0, 32'h20C);
        step();
        checks++;
        if (bus.o_retire !== 1'b0 || bus.o_rf_we !== 1'b0) begin
            failures++;
            $display("FAIL bubble got=%b/%b exp=0/0", bus.o_retire, bus.o_rf_we);
        end
    endtask

    task automatic test_stall_flush();
        drive(R_OP, 3'd0, 5'd9, 1'b1, 32'h11111111, 2'd0, 32'h300);
        step();
        drive(R_OP, 3'd0, 5'd10, 1'b1, 32'h22222222, 2'd0, 32'h304);
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.o_rf_we !== 1'b0 || bus.o_retire !== 1'b0 ||
                bus.o_rf_data !== 32'h11111111 || bus.o_rf_addr !== 5'd9) begin
                failures++;
                $display("FAIL stall_%0d got=%b/%b/%h/%0d exp=0/0/11111111/9", i,
                         bus.o_rf_we, bus.o_retire, bus.o_rf_data, bus.o_rf_addr);
            end
        end
        bus.i_stall = 1'b0;
        step();
        checks++;
        if (bus.o_rf_we !== 1'b1 || bus.o_rf_data !== 32'h22222222 || bus.o_pc !== 32'h304) begin
            failures++;
            $display("FAIL unstall got=%b/%h/%h exp=1/22222222/304",
                     bus.o_rf_we, bus.o_rf_data, bus.o_pc);
        end
        bus.i_stall = 1'b1;
        bus.i_flush = 1'b1;
        step();
        checks++;
        if ({bus.o_rf_we, bus.o_retire, bus.o_load_fault} !== 3'b000 ||
            {bus.o_rf_addr, bus.o_rf_data, bus.o_pc} !== 69'h0) begin
            failures++;
            $display("FAIL flush got=%b%b%b/%h exp=000/0",
                     bus.o_rf_we, bus.o_retire, bus.o_load_fault,
                     {bus.o_rf_addr, bus.o_rf_data, bus.o_pc});
        end
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(L_OP, F3_LW, 5'd12, 1'b1, 32'hCAFEF00D, 2'd0, 32'h400);
        step();
        checks++;
        if (bus.o_rf_we !== 1'b1 || bus.o_rf_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL pre_reset got=%b/%h exp=1/cafef00d", bus.o_rf_we, bus.o_rf_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_rf_we, bus.o_retire, bus.o_load_fault} !== 3'b000 ||
            {bus.o_rf_addr, bus.o_rf_data, bus.o_pc} !== 69'h0) begin
            failures++;
            $display("FAIL async_reset got=%b%b%b/%h exp=000/0",
                     bus.o_rf_we, bus.o_retire, bus.o_load_fault,
                     {bus.o_rf_addr, bus.o_rf_data, bus.o_pc});
        end
        step();
        checks++;
        if (bus.o_rf_we !== 1'b0 || bus.o_retire !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b/%b exp=0/0", bus.o_rf_we, bus.o_retire);
        end
        #2 rst = 1'b0;
        drive(I_OP, 3'd0, 5'd13, 1'b1, 32'h0BADC0DE, 2'd0, 32'h408);
        step();
        checks++;
        if (bus.o_rf_we !== 1'b1 || bus.o_rf_data !== 32'h0BADC0DE ||
            bus.o_rf_addr !== 5'd13 || bus.o_retire !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got=%b/%h/%0d/%b exp=1/0badc0de/13/1",
                     bus.o_rf_we, bus.o_rf_data, bus.o_rf_addr, bus.o_retire);
        end
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret_wrap();
        drive(I_OP, 3'd0, 5'd1, 1'b1, 32'h1, 2'd0, 32'h500);
        step();
        checks++;
        if (instret !== 64'd2) begin
            failures++;
            $display("FAIL instret_count got=%0d exp=2", instret);
        end
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        step();
        checks++;
        if (instret !== 64'd0) begin
            failures++;
            $display("FAIL instret_wrap got=%h exp=0", instret);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_lb();
        test_load_half_word();
        test_alu();
        test_stall_flush();
        test_async_reset();
`ifdef WB_INSTRET_EN
        test_instret_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
